// File: rtl/enc_pkg.sv
// Shared widths and types for the SEC-DED encoder arbiter slice.
// 32-bit data words encode to 39-bit codewords.
package enc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CODE_W = 39;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/enc_rr_arb.sv
// Round-robin grant for the shared encoder: the first valid requester at or
// above ptr (wrapping at NUM_REQ-1) wins; ptr moves past the winner on accept.
module enc_rr_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               adv,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] idx;
    int unsigned     sum;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        sum      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // Explicit wrap so non-power-of-two NUM_REQ never indexes past the last port.
            sum = 32'(ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_W'(sum);
            if (!any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                any        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any && adv) begin
            ptr <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/enc_arb.sv
// Arbitrates NUM_REQ writers onto one external SEC-DED encoder (S1 -> OUT pipe).
// Optional ENC_ERR_INJECT_EN adds a one-shot codeword error injector.
module enc_arb
    import enc_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         enc_in,
    input  logic [CODE_W-1:0]         enc_out,
    output logic                      out_valid,
    output logic [CODE_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          cw_count
`ifdef ENC_ERR_INJECT_EN
    ,
    input  logic                      inj_arm,
    input  logic [CODE_W-1:0]         inj_mask
`endif
);

    logic               s1_valid;
    logic [DATA_W-1:0]  s1_data;
    logic [ID_W-1:0]    s1_id;
    logic               out_adv;
    logic               s1_adv;
    logic               accept;
    logic               any;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gid;
    logic [DATA_W-1:0]  sel_data;
    logic [CODE_W-1:0]  cap;

    assign out_adv   = !out_valid || out_ready;
    assign s1_adv    = !s1_valid || out_adv;
    assign req_ready = s1_adv ? grant : '0;
    assign accept    = any && s1_adv;
    assign enc_in    = s1_data;

    enc_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid    (req_valid),
        .adv      (s1_adv),
        .grant    (grant),
        .grant_id (gid),
        .any      (any)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(gid) == i) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ENC_ERR_INJECT_EN
    logic              armed;
    logic [CODE_W-1:0] mask;

    // A capture on the arming edge still uses the old state; arming wins the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
            mask  <= '0;
        end else if (inj_arm) begin
            armed <= 1'b1;
            mask  <= inj_mask;
        end else if (out_adv && s1_valid) begin
            armed <= 1'b0;
        end
    end

    assign cap = armed ? (enc_out ^ mask) : enc_out;
`else
    assign cap = enc_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            cw_count  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= sel_data;
                    s1_id   <= gid;
                end
            end
            if (out_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= cap;
                    out_id   <= s1_id;
                end
            end
            if (out_valid && out_ready) begin
                cw_count <= cw_count + CNT_W'(1);
            end
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_id)));

endmodule

// File: tb/tb_enc_arb.sv
// Directed bench for enc_arb with a software SEC-DED encoder on enc_in/enc_out.
// Define ENC_ERR_INJECT_EN to also exercise the error injector.
module tb_enc_arb;
    import enc_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [31:0]               d [4];
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         enc_in;
    logic [CODE_W-1:0]         enc_out;
    logic                      out_valid;
    logic [CODE_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;
    logic [CNT_W-1:0]          cw_count;
`ifdef ENC_ERR_INJECT_EN
    logic                      inj_arm;
    logic [CODE_W-1:0]         inj_mask;
`endif

    always #5 clk = ~clk;

    // Hamming(38,32) with parity at power-of-two positions, bit 0 = overall parity.
    function automatic logic [38:0] secded(input logic [31:0] dat);
        logic [38:0] c;
        int          k;
        logic        x;
        c = '0;
        k = 0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = dat[k];
                k++;
            end
        end
        for (int b = 0; b < 6; b++) begin
            x = 1'b0;
            for (int p = 1; p < 39; p++) begin
                if (((p & (1 << b)) != 0) && (p != (1 << b))) x = x ^ c[p];
            end
            c[1 << b] = x;
        end
        c[0] = ^c[38:1];
        return c;
    endfunction

    assign req_data = {d[3], d[2], d[1], d[0]};
    assign enc_out  = secded(enc_in);

    enc_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .enc_in    (enc_in),
        .enc_out   (enc_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .cw_count  (cw_count)
`ifdef ENC_ERR_INJECT_EN
        ,
        .inj_arm   (inj_arm),
        .inj_mask  (inj_mask)
`endif
    );

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [38:0]     code;
    } item_t;

    typedef struct {
        logic [3:0]  vmask;
        logic [31:0] dat [4];
        int          n;
        int          ids [4];
    } vec_t;

    item_t got [$];
    item_t exp [$];
    vec_t  vecs [5];
    int    nchk = 0;
    int    nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: settle inputs, record handshakes, cross the edge, retire accepted requests.
    task automatic tick();
        logic [3:0] acc;
        #4;
        acc = req_valid & req_ready;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) exp.push_back('{id: ID_W'(i), code: secded(d[i])});
        end
        if (out_valid && out_ready) got.push_back('{id: out_id, code: out_data});
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
`ifdef ENC_ERR_INJECT_EN
        inj_arm   = 1'b0;
        inj_mask  = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
        got.delete();
        exp.delete();
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < 30 && got.size() < n; c++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] t2 [4];
        logic [31:0] dx;
        t2 = '{32'd1979398776, 32'd1010226197, 32'd3597602390, 32'd1658316396};
        vecs[0] = '{vmask: 4'b0001, dat: '{32'd0, 32'd0, 32'd0, 32'd0}, n: 1, ids: '{0, 0, 0, 0}};
        vecs[1] = '{vmask: 4'b1111, dat: t2, n: 4, ids: '{0, 1, 2, 3}};
        vecs[2] = '{vmask: 4'b1010, dat: '{32'd0, 32'hdeadbeef, 32'd0, 32'h01234567}, n: 2, ids: '{1, 3, 0, 0}};
        vecs[3] = '{vmask: 4'b0110, dat: '{32'd0, 32'h80000001, 32'h7fffffff, 32'd0}, n: 2, ids: '{1, 2, 0, 0}};
        vecs[4] = '{vmask: 4'b1000, dat: '{32'd0, 32'd0, 32'd0, 32'hffffffff}, n: 1, ids: '{3, 0, 0, 0}};
        for (int i = 0; i < 4; i++) d[i] = '0;

        @(posedge clk);
        #1;
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_id", 64'(out_id), 64'd0);
        check("rst_cw_count", 64'(cw_count), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_enc_in", 64'(enc_in), 64'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < 4; i++) d[i] = vecs[v].dat[i];
            req_valid = vecs[v].vmask;
            tick();
            check("lat_edge1_valid", 64'(out_valid), 64'd0);
            tick();
            check("lat_edge2_valid", 64'(out_valid), 64'd1);
            drain(vecs[v].n);
            check("row_count", 64'(got.size()), 64'(vecs[v].n));
            for (int k = 0; k < vecs[v].n && k < got.size(); k++) begin
                check("row_id", 64'(got[k].id), 64'(vecs[v].ids[k]));
                check("row_code", 64'(got[k].code), 64'(secded(vecs[v].dat[vecs[v].ids[k]])));
            end
            check("row_cw_count", 64'(cw_count), 64'(vecs[v].n));
        end

        // Backpressure: two words buffered, then an in-order release.
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = t2[i];
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) tick();
        check("bp_accepted", 64'(exp.size()), 64'd2);
        check("bp_req_ready", 64'(req_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_id", 64'(out_id), 64'd0);
        check("bp_out_data", 64'(out_data), 64'(secded(t2[0])));
        out_ready = 1'b1;
        drain(4);
        check("bp_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            check("bp_id", 64'(got[k].id), 64'(k));
            check("bp_code", 64'(got[k].code), 64'(secded(t2[k])));
        end
        tick();
        check("bp_no_dup", 64'(got.size()), 64'd4);
        check("bp_cw_count", 64'(cw_count), 64'd4);

        // Fairness: after 3 wins, 0 outranks a re-requesting 3.
        do_reset();
        d[3] = 32'h000055aa;
        req_valid = 4'b1000;
        tick();
        d[3] = 32'h00001234;
        d[0] = 32'h0000abcd;
        req_valid = 4'b1001;
        #1;
        check("fair_grant", 64'(req_ready), 64'b0001);
        drain(3);
        check("fair_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            check("fair_id0", 64'(got[0].id), 64'd3);
            check("fair_code0", 64'(got[0].code), 64'(secded(32'h000055aa)));
            check("fair_id1", 64'(got[1].id), 64'd0);
            check("fair_code1", 64'(got[1].code), 64'(secded(32'h0000abcd)));
            check("fair_id2", 64'(got[2].id), 64'd3);
            check("fair_code2", 64'(got[2].code), 64'(secded(32'h00001234)));
        end

        // Reset with S1 and OUT both full.
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = t2[i];
        req_valid = 4'b1111;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        check("mid_pre_count", 64'(cw_count), 64'd1);
        rst = 1'b1;
        req_valid = '0;
        tick();
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_cw_count", 64'(cw_count), 64'd0);
        check("mid_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        got.delete();
        exp.delete();
        req_valid = 4'b1111;
        #1;
        check("mid_ptr_zero", 64'(req_ready), 64'b0001);
        req_valid = 4'b0100;
        #1;
        check("mid_grant2", 64'(req_ready), 64'b0100);
        drain(1);
        check("mid_count", 64'(got.size()), 64'd1);
        if (got.size() == 1) begin
            check("mid_id", 64'(got[0].id), 64'd2);
            check("mid_code", 64'(got[0].code), 64'(secded(t2[2])));
        end
        tick();
        tick();
        check("mid_drained", 64'(got.size()), 64'd1);

`ifdef ENC_ERR_INJECT_EN
        do_reset();
        inj_mask = 39'h20;
        inj_arm  = 1'b1;
        tick();
        inj_arm  = 1'b0;
        inj_mask = '0;
        dx = 32'd374275781;
        d[0] = dx;
        req_valid = 4'b0001;
        tick();
        d[0] = 32'h0f0f0f0f;
        req_valid = 4'b0001;
        drain(2);
        check("inj_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            check("inj_flip", 64'(got[0].code), 64'(secded(dx) ^ 39'h20));
            check("inj_clean", 64'(got[1].code), 64'(secded(32'h0f0f0f0f)));
        end
`else
        dx = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
